ps2_kbd_wb: RTL and testbench

Parametrised Wishbone-slave PS/2 keyboard receiver for the CPU I/O bus. It replaces the single-byte keyboard port with a fully synchronous, one-clock design that adds:
- frame deserialisation with odd-parity and framing checks;
- a stall timeout;
- a configurable-depth scan-code FIFO;
- status and control registers, plus a level interrupt.

It sits between the PS/2 connector pins and the bus decoder, beside the other Wishbone I/O slaves.

---
 rtl/ps2_pkg.sv | 45 ++++
 rtl/ps2_rx_frame.sv | 122 ++++++++++++
 rtl/ps2_kbd_wb.sv | 147 ++++++++++++++
 tb/tb_ps2_kbd_wb.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants, register map and types for the PS/2 keyboard Wishbone slave.
package ps2_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_LAST   = 2'd3;

  localparam int unsigned ST_EMPTY      = 0;
  localparam int unsigned ST_FULL       = 1;
  localparam int unsigned ST_OVERFLOW   = 2;
  localparam int unsigned ST_PARITY_ERR = 3;
  localparam int unsigned ST_FRAME_ERR  = 4;
  localparam int unsigned ST_COUNT_LSB  = 8;

  localparam int unsigned CTRL_IRQ_EN = 0;
  localparam int unsigned CTRL_RX_EN  = 1;
  localparam int unsigned CTRL_FLUSH  = 2;

  localparam int unsigned FRAME_LEN = 11;
  localparam int unsigned BIT_CNT_W = 4;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_SHIFT = 2'd1,
    RX_CHECK = 2'd2
  } rx_state_e;

  typedef struct packed {
    logic [15:0] rsvd_hi;
    logic [7:0]  count;
    logic [2:0]  rsvd_lo;
    logic        frame_err;
    logic        parity_err;
    logic        overflow;
    logic        full;
    logic        empty;
  } ps2_status_t;

  // Odd parity holds when data plus parity bit carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: pin synchronisers, falling-edge detect, 11-bit shifter,
// start/stop/parity checks and a mid-frame stall timeout.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rx_en,
  output logic       byte_valid_c,
  output logic [7:0] rx_byte_c,
  output logic       parity_err_c,
  output logic       frame_err_c
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;
  logic                   clk_s;
  logic                   data_s;
  logic                   fall_c;

  rx_state_e              state, state_nxt;
  logic [BIT_CNT_W-1:0]   bit_cnt, bit_cnt_nxt;
  logic [FRAME_LEN-1:0]   frame, frame_nxt;
  logic [TW-1:0]          timer, timer_nxt;

  // Synchronisers reset to the idle-high line level so reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_s;
    end
  end

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];
  assign fall_c = clk_prev & ~clk_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RX_IDLE;
      bit_cnt <= '0;
      frame   <= '0;
      timer   <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      frame   <= frame_nxt;
      timer   <= timer_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    frame_nxt    = frame;
    timer_nxt    = '0;
    byte_valid_c = 1'b0;
    parity_err_c = 1'b0;
    frame_err_c  = 1'b0;
    rx_byte_c    = frame[8:1];

    if (!rx_en) begin
      state_nxt   = RX_IDLE;
      bit_cnt_nxt = '0;
    end else begin
      unique case (state)
        RX_IDLE: begin
          if (fall_c) begin
            frame_nxt   = {{(FRAME_LEN-1){1'b0}}, data_s};
            bit_cnt_nxt = BIT_CNT_W'(1);
            state_nxt   = RX_SHIFT;
          end
        end
        RX_SHIFT: begin
          if (fall_c) begin
            frame_nxt[bit_cnt] = data_s;
            if (bit_cnt == BIT_CNT_W'(FRAME_LEN - 1)) begin
              state_nxt = RX_CHECK;
            end else begin
              bit_cnt_nxt = bit_cnt + BIT_CNT_W'(1);
            end
          end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
            frame_err_c = 1'b1;
            state_nxt   = RX_IDLE;
            bit_cnt_nxt = '0;
          end else begin
            timer_nxt = timer + TW'(1);
          end
        end
        RX_CHECK: begin
          state_nxt   = RX_IDLE;
          bit_cnt_nxt = '0;
          if (frame[0] || !frame[FRAME_LEN-1]) begin
            frame_err_c = 1'b1;
          end else if (!odd_parity_ok(frame[8:1], frame[9])) begin
            parity_err_c = 1'b1;
          end else begin
            byte_valid_c = 1'b1;
          end
        end
        default: begin
          state_nxt   = RX_IDLE;
          bit_cnt_nxt = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/ps2_kbd_wb.sv
// Wishbone slave PS/2 keyboard port: receiver, scan-code FIFO, status/control
// registers and a level interrupt.
module ps2_kbd_wb
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PS2_clk,
  input  logic        PS2_Data,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic        ps2_irq,
  output logic [31:0] key_d
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          overflow, parity_err, frame_err;
  logic          irq_en, rx_en;

  logic          byte_valid_c, parity_err_c, frame_err_c;
  logic [7:0]    rx_byte_c;

  logic          access_c, rd_c, wr_c;
  logic [1:0]    reg_sel_c;
  logic          empty_c, full_c, push_c, pop_c, flush_c;
  logic          clr_ovf_c, clr_perr_c, clr_ferr_c;
  ps2_status_t   status_c;
  logic [31:0]   rdata_c;
  logic          unused_bits;

  ps2_rx_frame #(
    .SYNC_STAGES   (SYNC_STAGES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk     (PS2_clk),
    .ps2_data    (PS2_Data),
    .rx_en       (rx_en),
    .byte_valid_c(byte_valid_c),
    .rx_byte_c   (rx_byte_c),
    .parity_err_c(parity_err_c),
    .frame_err_c (frame_err_c)
  );

  assign unused_bits = ^{adr_i[31:4], adr_i[1:0], dat_i[31:5]};

  // Bus decode; an access is only taken when the previous ack has dropped.
  always_comb begin
    reg_sel_c  = adr_i[3:2];
    access_c   = stb_i & ~ack_o;
    rd_c       = access_c & ~we_i;
    wr_c       = access_c & we_i;
    empty_c    = (count == '0);
    full_c     = (count == CW'(FIFO_DEPTH));
    pop_c      = rd_c & (reg_sel_c == REG_DATA) & ~empty_c;
    push_c     = byte_valid_c & ~full_c;
    flush_c    = wr_c & (reg_sel_c == REG_CTRL) & dat_i[CTRL_FLUSH];
    clr_ovf_c  = wr_c & (reg_sel_c == REG_STATUS) & dat_i[ST_OVERFLOW];
    clr_perr_c = wr_c & (reg_sel_c == REG_STATUS) & dat_i[ST_PARITY_ERR];
    clr_ferr_c = wr_c & (reg_sel_c == REG_STATUS) & dat_i[ST_FRAME_ERR];
  end

  always_comb begin
    status_c            = '0;
    status_c.empty      = empty_c;
    status_c.full       = full_c;
    status_c.overflow   = overflow;
    status_c.parity_err = parity_err;
    status_c.frame_err  = frame_err;
    status_c.count      = 8'(count);

    rdata_c = '0;
    if (!we_i) begin
      unique case (reg_sel_c)
        REG_DATA:   rdata_c = empty_c ? 32'h0 : {23'h0, 1'b1, mem[rd_ptr]};
        REG_STATUS: rdata_c = status_c;
        REG_CTRL:   rdata_c = {30'h0, rx_en, irq_en};
        REG_LAST:   rdata_c = key_d;
        default:    rdata_c = '0;
      endcase
    end
  end

  // FIFO storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= rx_byte_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dat_o      <= '0;
      ack_o      <= 1'b0;
      ps2_irq    <= 1'b0;
      key_d      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      irq_en     <= 1'b0;
      rx_en      <= 1'b1;
    end else begin
      ack_o <= access_c;
      if (access_c) dat_o <= rdata_c;

      if (flush_c) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_c) wr_ptr <= wr_ptr + PW'(1);
        if (pop_c)  rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push_c) - CW'(pop_c);
      end

      if (byte_valid_c) key_d <= {key_d[23:0], rx_byte_c};

      // A new event outranks a clear landing in the same cycle.
      overflow   <= (overflow & ~clr_ovf_c) | (byte_valid_c & full_c);
      parity_err <= (parity_err & ~clr_perr_c) | parity_err_c;
      frame_err  <= (frame_err & ~clr_ferr_c) | frame_err_c;

      if (wr_c && (reg_sel_c == REG_CTRL)) begin
        irq_en <= dat_i[CTRL_IRQ_EN];
        rx_en  <= dat_i[CTRL_RX_EN];
      end

      ps2_irq <= irq_en & (~empty_c | overflow | parity_err | frame_err);
    end
  end

endmodule

// File: tb/tb_ps2_kbd_wb.sv
// Directed bench for ps2_kbd_wb with a scan-code scoreboard and immediate assertions.
module tb_ps2_kbd_wb;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TO    = 200;

  logic        clk;
  logic        rst;
  logic        PS2_clk;
  logic        PS2_Data;
  logic        stb_i;
  logic        we_i;
  logic [31:0] adr_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        ack_o;
  logic        ps2_irq;
  logic [31:0] key_d;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  model_q[$];
  logic [31:0] model_kd;
  logic [31:0] rd;
  logic [10:0] fr;

  ps2_kbd_wb #(
    .FIFO_DEPTH    (DEPTH),
    .SYNC_STAGES   (2),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .PS2_clk (PS2_clk),
    .PS2_Data(PS2_Data),
    .stb_i   (stb_i),
    .we_i    (we_i),
    .adr_i   (adr_i),
    .dat_i   (dat_i),
    .dat_o   (dat_o),
    .ack_o   (ack_o),
    .ps2_irq (ps2_irq),
    .key_d   (key_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input logic flip, input logic stop);
    return {stop, (~^b) ^ flip, b, 1'b0};
  endfunction

  function automatic logic [31:0] st(input logic e, input logic f, input logic o,
                                     input logic p, input logic fe, input int cnt);
    return {16'h0, 8'(cnt), 3'b0, fe, p, o, f, e};
  endfunction

  task automatic ps2_bit(input logic b);
    PS2_Data = b;
    tick(4);
    PS2_clk = 1'b0;
    tick(8);
    PS2_clk = 1'b1;
    tick(4);
  endtask

  task automatic send_bits(input logic [10:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
    PS2_Data = 1'b1;
    tick(4);
  endtask

  // Sends a well-formed frame and records what the FIFO and key_d should hold.
  task automatic send_good(input logic [7:0] b);
    send_bits(make_frame(b, 1'b0, 1'b1), 11);
    if (model_q.size() < DEPTH) model_q.push_back(b);
    model_kd = {model_kd[23:0], b};
  endtask

  task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                     output logic [31:0] rdat);
    logic got;
    got   = 1'b0;
    rdat  = 'x;
    stb_i = 1'b1;
    we_i  = we;
    adr_i = adr;
    dat_i = wdat;
    for (int i = 0; i < 4 && !got; i++) begin
      tick(1);
      if (ack_o) begin
        got  = 1'b1;
        rdat = dat_o;
      end
    end
    stb_i = 1'b0;
    we_i  = 1'b0;
    check("ack_seen", 32'(got), 32'h1);
  endtask

  task automatic rd_reg(input logic [31:0] adr, input logic [31:0] exp, input string tag);
    logic [31:0] r;
    bus(1'b0, adr, 32'h0, r);
    check(tag, r, exp);
  endtask

  task automatic wr_reg(input logic [31:0] adr, input logic [31:0] wdat);
    logic [31:0] r;
    bus(1'b1, adr, wdat, r);
  endtask

  task automatic read_data(input string tag);
    logic [31:0] r;
    logic [31:0] exp;
    bus(1'b0, 32'h0, 32'h0, r);
    exp = 32'h0;
    if (model_q.size() > 0) exp = {23'h0, 1'b1, model_q.pop_front()};
    check(tag, r, exp);
  endtask

  initial begin
    rst = 1'b1; PS2_clk = 1'b1; PS2_Data = 1'b1;
    stb_i = 1'b0; we_i = 1'b0; adr_i = '0; dat_i = '0;
    model_kd = '0;
    tick(3);
    check("rst_dat_o", dat_o, 32'h0);
    check("rst_ack", 32'(ack_o), 32'h0);
    check("rst_irq", 32'(ps2_irq), 32'h0);
    check("rst_key_d", key_d, 32'h0);
    rst = 1'b0;
    tick(2);
    rd_reg(32'h4, st(1, 0, 0, 0, 0, 0), "rst_status");
    rd_reg(32'h8, 32'h2, "rst_ctrl");

    // Single byte, then empty read.
    send_good(8'h1C);
    tick(4);
    read_data("data_1c");
    tick(1);
    check("ack_one_cycle", 32'(ack_o), 32'h0);
    read_data("data_empty");
    rd_reg(32'h4, st(1, 0, 0, 0, 0, 0), "status_empty");

    // Interrupt with two queued bytes.
    wr_reg(32'h8, 32'h3);
    send_good(8'hF0);
    send_good(8'h1C);
    tick(4);
    check("irq_set", 32'(ps2_irq), 32'h1);
    rd_reg(32'h4, st(0, 0, 0, 0, 0, 2), "status_cnt2");
    read_data("data_f0");
    read_data("data_1c_b");
    check("irq_lag", 32'(ps2_irq), 32'h1);
    tick(1);
    check("irq_clear", 32'(ps2_irq), 32'h0);
    check("key_d_hist", key_d, model_kd);
    rd_reg(32'hC, model_kd, "last_reg");

    // Overflow: DEPTH+1 bytes, last one dropped from the FIFO but kept in key_d.
    send_good(8'h11); send_good(8'h22); send_good(8'h33);
    send_good(8'h44); send_good(8'h55);
    tick(4);
    rd_reg(32'h4, st(0, 1, 1, 0, 0, DEPTH), "status_ovf");
    check("key_d_ovf", key_d, model_kd);
    check("irq_ovf", 32'(ps2_irq), 32'h1);
    wr_reg(32'h4, 32'h4);
    rd_reg(32'h4, st(0, 1, 0, 0, 0, DEPTH), "status_ovf_clr");
    for (int i = 0; i < DEPTH; i++) read_data("drain");
    read_data("drain_empty");

    // Parity and framing errors discard the byte.
    send_bits(make_frame(8'h1C, 1'b1, 1'b1), 11);
    tick(4);
    rd_reg(32'h4, st(1, 0, 0, 1, 0, 0), "status_perr");
    send_bits(make_frame(8'h1C, 1'b0, 1'b0), 11);
    tick(4);
    rd_reg(32'h4, st(1, 0, 0, 1, 1, 0), "status_ferr");
    check("key_d_err", key_d, model_kd);
    wr_reg(32'h4, 32'h1C);
    rd_reg(32'h4, st(1, 0, 0, 0, 0, 0), "status_w1c");

    // Stall timeout mid-frame, then recovery.
    send_bits(make_frame(8'h29, 1'b0, 1'b1), 4);
    tick(TO + 20);
    rd_reg(32'h4, st(1, 0, 0, 0, 1, 0), "status_timeout");
    wr_reg(32'h4, 32'h10);
    send_good(8'h29);
    tick(4);
    read_data("data_29");

    // Flush lands in the same cycle as a push: flush wins.
    send_good(8'h01); send_good(8'h02); send_good(8'h03);
    tick(4);
    rd_reg(32'h4, st(0, 0, 0, 0, 0, 3), "status_cnt3");
    fr = make_frame(8'h04, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) ps2_bit(fr[i]);
    PS2_Data = 1'b1;
    tick(4);
    PS2_clk = 1'b0;
    tick(3);
    stb_i = 1'b1; we_i = 1'b1; adr_i = 32'h8; dat_i = 32'h7;
    tick(1);
    check("flush_ack", 32'(ack_o), 32'h1);
    stb_i = 1'b0; we_i = 1'b0;
    model_q.delete();
    model_kd = {model_kd[23:0], 8'h04};
    tick(7);
    PS2_clk = 1'b1;
    tick(4);
    rd_reg(32'h4, st(1, 0, 0, 0, 0, 0), "status_flush");
    check("key_d_flush", key_d, model_kd);
    send_good(8'h05);
    tick(4);
    read_data("data_after_flush");

    // Reset mid-frame.
    send_bits(make_frame(8'h5A, 1'b0, 1'b1), 5);
    rst = 1'b1;
    tick(2);
    check("mrst_dat_o", dat_o, 32'h0);
    check("mrst_ack", 32'(ack_o), 32'h0);
    check("mrst_irq", 32'(ps2_irq), 32'h0);
    check("mrst_key_d", key_d, 32'h0);
    rst = 1'b0;
    model_kd = '0;
    model_q.delete();
    tick(2);
    rd_reg(32'h4, st(1, 0, 0, 0, 0, 0), "mrst_status");
    rd_reg(32'h8, 32'h2, "mrst_ctrl");
    send_good(8'h29);
    tick(4);
    read_data("mrst_data_29");
    check("mrst_key_d_29", key_d, model_kd);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
